mau_controller: RTL and testbench
=================================

Name: mau_controller

Overview:
- Sequencer for the Matrix Algebra Unit datapath: decodes host instruction bytes and drives the four BRAM enables, byte offset, AA/DD operand muxes, arithmetic mux, BRAM copy/input muxes and host readback select.
- Sits between the host byte interface and the MAU datapath; the MAU top replaces its loose select wires with this block's outputs.
- One instruction at a time; `busy` is high while an instruction is in flight.

Parameters:
- MATRIX_DIM, 8, matrix edge length in elements.
- NUM_BYTES, MATRIX_DIM*MATRIX_DIM, bytes per matrix chunk; must be ≤ 512 (9-bit offset).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- host_instruction  in  8  instruction byte
- instr_valid  in  1  host_instruction valid this cycle
- data_valid  in  1  data_in byte valid (LOAD)
- arith_done  in  1  selected arithmetic unit result stable
- offset  out  9  byte index to all BRAMs
- line_read_from_host  out  4  one-hot per-BRAM host byte write enable
- chunk_read_from_bram  out  4  one-hot per-BRAM chunk write enable
- aa_mux_sel, dd_mux_sel  out  2 each  operand A / operand B BRAM select
- arithmetic_mux_sel  out  2  0 add, 1 shift, 2 sub, 3 mul
- bram_copy_mux_sel  out  2  copy-source BRAM
- bram_in_mux_sel  out  1  0 arithmetic result, 1 copy path
- shift_amt  out  4  shift amount to shifter
- arith_start  out  1  one-cycle start pulse to arithmetic units
- host_out_sel  out  2  which bram_to_host drives data_out
- host_out_valid  out  1  data_out byte valid (STORE)
- busy  out  1  instruction in progress
- op_done  out  1  one-cycle pulse at instruction completion
- illegal_op  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Byte0 encoding: [7:4] opcode, [3:2] dest BRAM, [1:0] reserved (ignored).
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 MUL, 6 SHIFT, 7 COPY; 8–15 illegal.
- Byte1 (ops 3–7 only): [7:6] srcA, [5:4] srcB, [3:0] shift amount.
- States: IDLE, FETCH2, LOAD, STORE, EXEC, WAIT, WRITEBACK.
- IDLE:
  - instr_valid with NOP: op_done pulses next cycle, busy stays 0.
  - Illegal opcode: illegal_op pulses next cycle, stays IDLE, busy stays 0.
  - LOAD: go to LOAD. STORE: go to STORE. Ops 3–7: go to FETCH2.
  - busy is 1 from the cycle after byte0 is accepted.
- FETCH2: waits for instr_valid, then latches srcA, srcB and shift_amt. COPY goes to WRITEBACK; others go to EXEC.
- LOAD:
  - Each cycle with data_valid: line_read_from_host[dest]=1, offset=count, then count++.
  - Enable is 0 in cycles without data_valid.
  - After byte NUM_BYTES-1 is accepted: op_done pulse, go to IDLE.
- STORE:
  - BRAM read latency is 1 cycle. Offset steps 0..NUM_BYTES-1, one per cycle, no stalls.
  - host_out_valid is high in the cycle after each offset is presented, so exactly NUM_BYTES valid cycles.
  - host_out_sel=dest throughout.
  - op_done pulses with the last valid byte.
- EXEC: one cycle.
  - aa_mux_sel=srcA, dd_mux_sel=srcB, arithmetic_mux_sel per opcode (ADD 0, SHIFT 1, SUB 2, MUL 3).
  - arith_start=1, then go to WAIT.
- WAIT: hold all selects until arith_done=1; no timeout. arith_done may arrive in the first WAIT cycle.
- WRITEBACK: one cycle.
  - chunk_read_from_bram[dest]=1.
  - bram_in_mux_sel=1 for COPY (bram_copy_mux_sel=srcA), else 0.
  - op_done pulses, go to IDLE.
- Selects hold their last value outside active states. All enables are one-hot or zero, never multi-hot.
- dest equal to a source is legal: the operand is consumed before the WRITEBACK edge.
- instr_valid while busy: ignored and dropped, except in FETCH2 where it is byte1.
- Reset (rst=0 at a clock edge), including mid-LOAD/STORE/WAIT:
  - State IDLE, count 0.
  - All enables, pulses, busy and host_out_valid go to 0.
  - All selects, offset and shift_amt go to 0.
  - Partially loaded BRAM contents are not restored.
- count is 9 bits and never wraps: the terminal compare is at NUM_BYTES-1.

Decomposition:
- Package mau_pkg holds:
  - opcode localparams (OP_NOP..OP_COPY)
  - state encoding
  - arithmetic mux select constants (SEL_ADD=0, SEL_SHIFT=1, SEL_SUB=2, SEL_MUL=3)
  - the NUM_BYTES function.
- One sub-module, mau_offset_counter: 9-bit counter with clear, enable and terminal flag at NUM_BYTES-1. It is shared by LOAD and STORE.

Test Plan:
- LOAD dest=2 (byte0 0x18), 64 data_valid bytes with 3 gap cycles → line_read_from_host=4'b0100 on exactly 64 cycles, offsets 0..63, op_done one cycle after the last byte, busy low after that.
- STORE dest=1 (0x24) → offsets 0..63 on consecutive cycles, host_out_valid high 64 cycles lagging by 1, host_out_sel=1, op_done with the 64th byte.
- ADD dest=3 (0x3C), byte1 0x10 (A=0, B=1), arith_done 4 cycles after arith_start → aa=0, dd=1, arith_sel=0, single arith_start, chunk_read_from_bram=4'b1000 for one cycle, bram_in_mux_sel=0.
- COPY dest=0 (0x70), byte1 0xC0 (src=3) → no arith_start, bram_copy_mux_sel=3, bram_in_mux_sel=1, chunk_read_from_bram=4'b0001 one cycle.
- Illegal 0xF0, then NOP 0x00, then instr_valid during a LOAD → illegal_op pulse with busy 0, op_done pulse for the NOP, mid-LOAD byte ignored with no enable change.
- rst=0 at byte 30 of a LOAD and again during WAIT → next cycle all outputs 0, state IDLE, a following LOAD starts at offset 0.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the Matrix Algebra Unit controller: opcodes, FSM states,
// arithmetic mux encodings and the chunk-size helper.
package mau_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_SHIFT = 4'd6;
    localparam logic [3:0] OP_COPY  = 4'd7;

    localparam logic [1:0] SEL_ADD   = 2'd0;
    localparam logic [1:0] SEL_SHIFT = 2'd1;
    localparam logic [1:0] SEL_SUB   = 2'd2;
    localparam logic [1:0] SEL_MUL   = 2'd3;

    localparam int OFFSET_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH2,
        ST_LOAD,
        ST_STORE,
        ST_EXEC,
        ST_WAIT,
        ST_WRITEBACK
    } mau_state_t;

    function automatic int mau_num_bytes(input int dim);
        return dim * dim;
    endfunction

    // Opcode to arithmetic mux select; non-arithmetic opcodes fall back to add.
    function automatic logic [1:0] mau_arith_sel(input logic [3:0] op);
        case (op)
            OP_SUB:   return SEL_SUB;
            OP_MUL:   return SEL_MUL;
            OP_SHIFT: return SEL_SHIFT;
            default:  return SEL_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mau_offset_counter.sv
// Byte offset counter shared by LOAD and STORE; saturates at the last byte of
// a chunk so it can never wrap back into the BRAM.
module mau_offset_counter
    import mau_pkg::*;
#(
    parameter int NUM_BYTES = 64
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_enable,
    output logic [OFFSET_W-1:0] o_count,
    output logic                o_terminal
);

    logic [OFFSET_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 9'd1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == 9'(NUM_BYTES - 1));

endmodule

// File: rtl/mau_controller.sv
// Instruction sequencer for the MAU datapath: decodes host instruction bytes and
// drives BRAM enables, offset, operand/arithmetic/copy muxes and host readback.
module mau_controller
    import mau_pkg::*;
#(
    parameter int MATRIX_DIM = 8,
    parameter int NUM_BYTES  = mau_num_bytes(MATRIX_DIM)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_instruction,
    input  logic       instr_valid,
    input  logic       data_valid,
    input  logic       arith_done,
    output logic [8:0] offset,
    output logic [3:0] line_read_from_host,
    output logic [3:0] chunk_read_from_bram,
    output logic [1:0] aa_mux_sel,
    output logic [1:0] dd_mux_sel,
    output logic [1:0] arithmetic_mux_sel,
    output logic [1:0] bram_copy_mux_sel,
    output logic       bram_in_mux_sel,
    output logic [3:0] shift_amt,
    output logic       arith_start,
    output logic [1:0] host_out_sel,
    output logic       host_out_valid,
    output logic       busy,
    output logic       op_done,
    output logic       illegal_op
);

    mau_state_t r_state;
    mau_state_t w_state_next;

    logic [3:0] r_op;
    logic [1:0] r_dest;
    logic       r_op_done;
    logic       r_illegal;
    logic       r_host_out_valid;
    logic [1:0] r_host_out_sel;
    logic [1:0] r_aa_sel;
    logic [1:0] r_dd_sel;
    logic [1:0] r_arith_sel;
    logic [1:0] r_copy_sel;
    logic       r_in_mux_sel;
    logic [3:0] r_shift_amt;

    logic [3:0]          w_opcode;
    logic [1:0]          w_dest;
    logic [OFFSET_W-1:0] w_count;
    logic                w_terminal;
    logic                w_cnt_clear;
    logic                w_cnt_enable;
    logic                w_load_wr;
    logic                w_writeback;
    logic                w_accept_byte0;
    logic                w_accept_byte1;
    logic                w_op_done_next;
    logic                w_illegal_next;
    logic                w_host_valid_next;
    logic                w_unused_bits;

    assign w_opcode      = host_instruction[7:4];
    assign w_dest        = host_instruction[3:2];
    assign w_unused_bits = ^host_instruction[1:0];

    mau_offset_counter #(
        .NUM_BYTES(NUM_BYTES)
    ) u_offset_counter (
        .clk        (clk),
        .i_rst_n    (rst),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_cnt_enable),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_state_next      = r_state;
        w_cnt_clear       = 1'b0;
        w_cnt_enable      = 1'b0;
        w_load_wr         = 1'b0;
        w_accept_byte0    = 1'b0;
        w_accept_byte1    = 1'b0;
        w_op_done_next    = 1'b0;
        w_illegal_next    = 1'b0;
        w_host_valid_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept_byte0 = 1'b1;
                    case (w_opcode)
                        OP_NOP:   w_op_done_next = 1'b1;
                        OP_LOAD: begin
                            w_state_next = ST_LOAD;
                            w_cnt_clear  = 1'b1;
                        end
                        OP_STORE: begin
                            w_state_next = ST_STORE;
                            w_cnt_clear  = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_SHIFT, OP_COPY:
                            w_state_next = ST_FETCH2;
                        default:  w_illegal_next = 1'b1;
                    endcase
                end
            end
            ST_FETCH2: begin
                if (instr_valid) begin
                    w_accept_byte1 = 1'b1;
                    w_state_next   = (r_op == OP_COPY) ? ST_WRITEBACK : ST_EXEC;
                end
            end
            ST_LOAD: begin
                if (data_valid) begin
                    w_load_wr    = 1'b1;
                    w_cnt_enable = 1'b1;
                    if (w_terminal) begin
                        w_state_next   = ST_IDLE;
                        w_op_done_next = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                // Read data appears one cycle after its offset, so valid trails by one.
                w_cnt_enable      = 1'b1;
                w_host_valid_next = 1'b1;
                if (w_terminal) begin
                    w_state_next   = ST_IDLE;
                    w_op_done_next = 1'b1;
                end
            end
            ST_EXEC:      w_state_next = ST_WAIT;
            ST_WAIT:      if (arith_done) w_state_next = ST_WRITEBACK;
            ST_WRITEBACK: w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_op             <= OP_NOP;
            r_dest           <= '0;
            r_op_done        <= 1'b0;
            r_illegal        <= 1'b0;
            r_host_out_valid <= 1'b0;
            r_host_out_sel   <= '0;
            r_aa_sel         <= '0;
            r_dd_sel         <= '0;
            r_arith_sel      <= '0;
            r_copy_sel       <= '0;
            r_in_mux_sel     <= 1'b0;
            r_shift_amt      <= '0;
        end else begin
            r_state          <= w_state_next;
            r_op_done        <= w_op_done_next;
            r_illegal        <= w_illegal_next;
            r_host_out_valid <= w_host_valid_next;
            if (w_accept_byte0) begin
                r_op   <= w_opcode;
                r_dest <= w_dest;
                if (w_opcode == OP_STORE) begin
                    r_host_out_sel <= w_dest;
                end
            end
            // Selects are updated only for the path the instruction uses; others hold.
            if (w_accept_byte1) begin
                r_shift_amt <= host_instruction[3:0];
                if (r_op == OP_COPY) begin
                    r_copy_sel   <= host_instruction[7:6];
                    r_in_mux_sel <= 1'b1;
                end else begin
                    r_aa_sel     <= host_instruction[7:6];
                    r_dd_sel     <= host_instruction[5:4];
                    r_arith_sel  <= mau_arith_sel(r_op);
                    r_in_mux_sel <= 1'b0;
                end
            end
        end
    end

    assign w_writeback = (r_state == ST_WRITEBACK);

    for (genvar gi = 0; gi < 4; gi++) begin : g_enables
        assign line_read_from_host[gi]  = w_load_wr   && (r_dest == 2'(gi));
        assign chunk_read_from_bram[gi] = w_writeback && (r_dest == 2'(gi));
    end

    assign offset             = w_count;
    assign aa_mux_sel         = r_aa_sel;
    assign dd_mux_sel         = r_dd_sel;
    assign arithmetic_mux_sel = r_arith_sel;
    assign bram_copy_mux_sel  = r_copy_sel;
    assign bram_in_mux_sel    = r_in_mux_sel;
    assign shift_amt          = r_shift_amt;
    assign arith_start        = (r_state == ST_EXEC);
    assign host_out_sel       = r_host_out_sel;
    assign host_out_valid     = r_host_out_valid;
    assign busy               = (r_state != ST_IDLE);
    assign op_done            = r_op_done | w_writeback;
    assign illegal_op         = r_illegal;

endmodule

// File: tb/tb_mau_controller.sv
// Directed bench for mau_controller: LOAD/STORE/ADD/COPY/SHIFT, illegal and NOP
// handling, dropped bytes while busy, and reset mid-LOAD and mid-WAIT.
module tb_mau_controller;

    logic       clk;
    logic       rst;
    logic [7:0] host_instruction;
    logic       instr_valid;
    logic       data_valid;
    logic       arith_done;
    logic [8:0] offset;
    logic [3:0] line_read_from_host;
    logic [3:0] chunk_read_from_bram;
    logic [1:0] aa_mux_sel;
    logic [1:0] dd_mux_sel;
    logic [1:0] arithmetic_mux_sel;
    logic [1:0] bram_copy_mux_sel;
    logic       bram_in_mux_sel;
    logic [3:0] shift_amt;
    logic       arith_start;
    logic [1:0] host_out_sel;
    logic       host_out_valid;
    logic       busy;
    logic       op_done;
    logic       illegal_op;

    int n_checks;
    int n_errors;

    mau_controller #(.MATRIX_DIM(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .host_instruction     (host_instruction),
        .instr_valid          (instr_valid),
        .data_valid           (data_valid),
        .arith_done           (arith_done),
        .offset               (offset),
        .line_read_from_host  (line_read_from_host),
        .chunk_read_from_bram (chunk_read_from_bram),
        .aa_mux_sel           (aa_mux_sel),
        .dd_mux_sel           (dd_mux_sel),
        .arithmetic_mux_sel   (arithmetic_mux_sel),
        .bram_copy_mux_sel    (bram_copy_mux_sel),
        .bram_in_mux_sel      (bram_in_mux_sel),
        .shift_amt            (shift_amt),
        .arith_start          (arith_start),
        .host_out_sel         (host_out_sel),
        .host_out_valid       (host_out_valid),
        .busy                 (busy),
        .op_done              (op_done),
        .illegal_op           (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are changed 1ns after the rising edge; checks run 1ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        host_instruction = 8'h00;
        instr_valid = 1'b0;
        data_valid = 1'b0;
        arith_done = 1'b0;
        repeat (2) @(posedge clk);

        // ---------------- reset state ----------------
        step(); rst = 1'b1; #1;
        check("rst_offset", offset, 0);
        check("rst_line", line_read_from_host, 0);
        check("rst_chunk", chunk_read_from_bram, 0);
        check("rst_aa", aa_mux_sel, 0);
        check("rst_dd", dd_mux_sel, 0);
        check("rst_arith", arithmetic_mux_sel, 0);
        check("rst_copy", bram_copy_mux_sel, 0);
        check("rst_inmux", bram_in_mux_sel, 0);
        check("rst_shift", shift_amt, 0);
        check("rst_start", arith_start, 0);
        check("rst_hsel", host_out_sel, 0);
        check("rst_hvalid", host_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", op_done, 0);
        check("rst_illegal", illegal_op, 0);

        // ---------------- LOAD dest=2 with 3 gaps and a dropped byte ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h18; #1;
        step(); instr_valid = 1'b0; #1;
        check("load_busy", busy, 1);
        check("load_gap0", line_read_from_host, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 10 || i == 40) begin
                step(); data_valid = 1'b0; instr_valid = (i == 40);
                host_instruction = 8'h24; #1;
                check("load_gap", line_read_from_host, 0);
            end
            step(); data_valid = 1'b1; instr_valid = (i == 5);
            host_instruction = 8'h24; #1;
            check("load_en", line_read_from_host, 4'b0100);
            check("load_off", offset, i);
        end
        step(); data_valid = 1'b0; instr_valid = 1'b0; #1;
        check("load_done", op_done, 1);
        check("load_busy_end", busy, 0);
        check("load_en_end", line_read_from_host, 0);
        step(); #1;
        check("load_done_pulse", op_done, 0);
        check("load_dropped_busy", busy, 0);
        check("load_dropped_hv", host_out_valid, 0);

        // ---------------- STORE dest=1 ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h24; #1;
        step(); instr_valid = 1'b0; #1;
        for (int k = 0; k < 64; k++) begin
            check("store_off", offset, k);
            check("store_hv", host_out_valid, (k != 0));
            check("store_hsel", host_out_sel, 1);
            check("store_busy", busy, 1);
            check("store_done_early", op_done, 0);
            step();
        end
        check("store_hv_last", host_out_valid, 1);
        check("store_done", op_done, 1);
        check("store_busy_end", busy, 0);
        step();
        check("store_hv_after", host_out_valid, 0);
        check("store_done_after", op_done, 0);

        // ---------------- ADD dest=3, A=0, B=1 ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h3C; #1;
        step(); host_instruction = 8'h10; #1;
        check("add_fetch_busy", busy, 1);
        check("add_fetch_start", arith_start, 0);
        step(); instr_valid = 1'b0; #1;
        check("add_start", arith_start, 1);
        check("add_aa", aa_mux_sel, 0);
        check("add_dd", dd_mux_sel, 1);
        check("add_sel", arithmetic_mux_sel, 0);
        check("add_chunk_exec", chunk_read_from_bram, 0);
        for (int w = 1; w <= 4; w++) begin
            step(); arith_done = (w == 4); #1;
            check("add_wait_start", arith_start, 0);
            check("add_wait_chunk", chunk_read_from_bram, 0);
            check("add_wait_busy", busy, 1);
            check("add_wait_dd", dd_mux_sel, 1);
        end
        step(); arith_done = 1'b0; #1;
        check("add_wb_chunk", chunk_read_from_bram, 4'b1000);
        check("add_wb_inmux", bram_in_mux_sel, 0);
        check("add_wb_done", op_done, 1);
        check("add_wb_start", arith_start, 0);
        step();
        check("add_after_chunk", chunk_read_from_bram, 0);
        check("add_after_done", op_done, 0);
        check("add_after_busy", busy, 0);

        // ---------------- COPY dest=0 from BRAM 3 ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h70; #1;
        step(); host_instruction = 8'hC0; #1;
        step(); instr_valid = 1'b0; #1;
        check("copy_chunk", chunk_read_from_bram, 4'b0001);
        check("copy_inmux", bram_in_mux_sel, 1);
        check("copy_src", bram_copy_mux_sel, 3);
        check("copy_start", arith_start, 0);
        check("copy_done", op_done, 1);
        step();
        check("copy_after_chunk", chunk_read_from_bram, 0);
        check("copy_after_busy", busy, 0);

        // ---------------- illegal then NOP ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'hF0; #1;
        step(); instr_valid = 1'b0; #1;
        check("ill_pulse", illegal_op, 1);
        check("ill_busy", busy, 0);
        check("ill_done", op_done, 0);
        step(); instr_valid = 1'b1; host_instruction = 8'h00; #1;
        check("ill_pulse_end", illegal_op, 0);
        step(); instr_valid = 1'b0; #1;
        check("nop_done", op_done, 1);
        check("nop_busy", busy, 0);
        check("nop_illegal", illegal_op, 0);
        step();
        check("nop_done_end", op_done, 0);

        // ---------------- reset at byte 30 of a LOAD ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h18; #1;
        step(); instr_valid = 1'b0; data_valid = 1'b1; #1;
        for (int i = 0; i < 30; i++) begin
            check("rl_off", offset, i);
            step();
        end
        check("rl_off30", offset, 30);
        rst = 1'b0; #1;
        step(); rst = 1'b1; data_valid = 1'b0; #1;
        check("rl_offset", offset, 0);
        check("rl_line", line_read_from_host, 0);
        check("rl_busy", busy, 0);
        check("rl_hsel", host_out_sel, 0);
        check("rl_copy", bram_copy_mux_sel, 0);
        check("rl_inmux", bram_in_mux_sel, 0);
        check("rl_dd", dd_mux_sel, 0);
        check("rl_done", op_done, 0);
        step(); instr_valid = 1'b1; host_instruction = 8'h14; #1;
        step(); instr_valid = 1'b0; data_valid = 1'b1; #1;
        check("rl_new_en", line_read_from_host, 4'b0010);
        check("rl_new_off0", offset, 0);
        step();
        check("rl_new_off1", offset, 1);
        rst = 1'b0;
        step(); rst = 1'b1; data_valid = 1'b0; #1;
        check("rl_abort_busy", busy, 0);

        // ---------------- SHIFT dest=0, A=2, B=3, amt=5, reset during WAIT ----------------
        step(); instr_valid = 1'b1; host_instruction = 8'h60; #1;
        step(); host_instruction = 8'hB5; #1;
        step(); instr_valid = 1'b0; #1;
        check("sh_start", arith_start, 1);
        check("sh_sel", arithmetic_mux_sel, 1);
        check("sh_aa", aa_mux_sel, 2);
        check("sh_dd", dd_mux_sel, 3);
        check("sh_amt", shift_amt, 5);
        step();
        check("sh_wait_busy", busy, 1);
        rst = 1'b0;
        step(); rst = 1'b1; #1;
        check("rw_aa", aa_mux_sel, 0);
        check("rw_dd", dd_mux_sel, 0);
        check("rw_amt", shift_amt, 0);
        check("rw_sel", arithmetic_mux_sel, 0);
        check("rw_busy", busy, 0);
        check("rw_start", arith_start, 0);
        step(); arith_done = 1'b1; #1;
        step(); arith_done = 1'b0; #1;
        check("rw_stale_done_chunk", chunk_read_from_bram, 0);
        check("rw_stale_done_opdone", op_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
